fpu_dispatch: RTL and testbench

FPU_DISPATCH -- requirements
Module: fpu_dispatch

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_req_fifo.sv | 71 +++++++
 rtl/fpu_dispatch.sv | 163 ++++++++++++++++
 tb/tb_fpu_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request dispatcher.
// Holds the FSM state encoding, the FPU opcode type and the default NaN result.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fsm_state_e;

    // Opcode is handed to the FPU untouched; the dispatcher never decodes it.
    typedef logic [1:0] fpu_op_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU dispatcher: power-of-two storage with wrapping
// pointers and an occupancy count that directly drives full/empty.
module fpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    // DEPTH is a power of two, so pointer wrap falls out of the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues FPU requests and runs them one at a time through a start/done FPU,
// returning each result (or a NaN with rsp_err on timeout) with its tag.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,

    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_op,
    output logic             fpu_start,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_r,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_r,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,

    output logic             busy
);

    localparam int DW    = 32 + 32 + 2 + TAG_W;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    fsm_state_e state_q, state_d;

    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    fpu_op_t          op_op_q, op_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rsp_r_q, rsp_r_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_wr_data;
    logic [DW-1:0]    fifo_rd_data;

    logic [31:0]      head_a;
    logic [31:0]      head_b;
    fpu_op_t          head_op;
    logic [TAG_W-1:0] head_tag;

    // req_ready depends only on the registered count, never on this cycle's pop.
    assign req_ready    = !fifo_full;
    assign fifo_push    = req_valid && req_ready;
    assign fifo_wr_data = {req_a, req_b, req_op, req_tag};
    assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
    assign {head_a, head_b, head_op, head_tag} = fifo_rd_data;

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // fpu_done is only looked at in WAIT; a done on the expiry cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_op_d   = op_op_q;
        tag_d     = tag_q;
        rsp_r_d   = rsp_r_q;
        rsp_err_d = rsp_err_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    op_a_d  = head_a;
                    op_b_d  = head_b;
                    op_op_d = head_op;
                    tag_d   = head_tag;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    rsp_r_d   = fpu_r;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    rsp_r_d   = FP_QNAN;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_op_q   <= '0;
            tag_q     <= '0;
            rsp_r_q   <= '0;
            rsp_err_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_op_q   <= op_op_d;
            tag_q     <= tag_d;
            rsp_r_q   <= rsp_r_d;
            rsp_err_q <= rsp_err_d;
            timer_q   <= timer_d;
        end
    end

    assign fpu_a     = op_a_q;
    assign fpu_b     = op_b_q;
    assign fpu_op    = op_op_q;
    assign fpu_start = (state_q == ST_ISSUE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_r     = rsp_r_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed self-checking bench for fpu_dispatch: single op, FIFO fill with
// stalled responses, timeout, done-at-expiry, spurious done and mid-op reset.
module tb_fpu_dispatch;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [1:0]       req_op = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_op;
    logic             fpu_start;
    logic             fpu_done;
    logic [31:0]      fpu_r;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_r;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    // FPU input is either driven by hand or by a small delay model computing a^b.
    logic        model_en = 1'b0;
    logic        model_done = 1'b0;
    logic [31:0] model_r = '0;
    int          model_cnt = 0;
    int          model_delay = 3;
    logic        man_done = 1'b0;
    logic [31:0] man_r = '0;

    assign fpu_done = model_en ? model_done : man_done;
    assign fpu_r    = model_en ? model_r : man_r;

    int checks = 0;
    int errors = 0;

    fpu_dispatch #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_op    (fpu_op),
        .fpu_start (fpu_start),
        .fpu_done  (fpu_done),
        .fpu_r     (fpu_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            model_done = 1'b0;
            if (model_en) begin
                if (model_cnt > 0) begin
                    model_cnt = model_cnt - 1;
                    if (model_cnt == 0) begin
                        model_done = 1'b1;
                    end
                end
                if (fpu_start) begin
                    model_cnt = model_delay;
                    model_r   = fpu_a ^ fpu_b;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
    endtask

    task automatic waitRsp(input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput("rsp_seen", rsp_valid, 1'b1);
    endtask

    logic [31:0]      fill_a [5];
    logic [31:0]      fill_b [5];
    logic [TAG_W-1:0] fill_t [5];
    logic             flag;

    initial begin
        $display("[TB] starting fpu_dispatch bench");

        // Reset state
        #12;
        checkOutput("rst_req_ready", req_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_fpu_start", fpu_start, 1'b0);
        checkOutput("rst_fpu_a", fpu_a, 32'h0);
        checkOutput("rst_rsp_r", rsp_r, 32'h0);
        checkOutput("rst_rsp_tag", rsp_tag, 5'd0);
        checkOutput("rst_rsp_err", rsp_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single op, hand-driven FPU
        applyStimulus(32'h3F800000, 32'h40000000, 2'd0, 5'd3);
        tick();
        req_valid = 1'b0;
        checkOutput("single_start_n1", fpu_start, 1'b0);
        checkOutput("single_busy", busy, 1'b1);
        tick();
        checkOutput("single_start_n2", fpu_start, 1'b1);
        checkOutput("single_fpu_a", fpu_a, 32'h3F800000);
        checkOutput("single_fpu_b", fpu_b, 32'h40000000);
        checkOutput("single_fpu_op", fpu_op, 2'd0);
        tick();
        checkOutput("single_start_pulse", fpu_start, 1'b0);
        repeat (4) tick();
        man_done = 1'b1;
        man_r    = 32'h40400000;
        tick();
        man_done = 1'b0;
        checkOutput("single_rsp_valid", rsp_valid, 1'b1);
        checkOutput("single_rsp_r", rsp_r, 32'h40400000);
        checkOutput("single_rsp_tag", rsp_tag, 5'd3);
        checkOutput("single_rsp_err", rsp_err, 1'b0);
        checkOutput("single_hold_a", fpu_a, 32'h3F800000);
        tick();
        checkOutput("single_rsp_drop", rsp_valid, 1'b0);
        checkOutput("single_idle_busy", busy, 1'b0);

        // Fill the FIFO while responses are stalled
        model_en  = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fill_a[i] = 32'h1000_0000 + 32'(i * 32'h0101);
            fill_b[i] = 32'h0F0F_0000 | 32'(i * 7);
            fill_t[i] = TAG_W'(10 + i);
            applyStimulus(fill_a[i], fill_b[i], 2'(i), fill_t[i]);
            checkOutput($sformatf("fill_ready_%0d", i), req_ready, 1'b1);
            tick();
        end
        req_valid = 1'b0;
        checkOutput("fill_full", req_ready, 1'b0);
        repeat (10) tick();
        checkOutput("fill_stall_valid", rsp_valid, 1'b1);
        checkOutput("fill_stall_tag", rsp_tag, fill_t[0]);
        checkOutput("fill_still_full", req_ready, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitRsp(40);
            checkOutput($sformatf("fill_tag_%0d", i), rsp_tag, fill_t[i]);
            checkOutput($sformatf("fill_r_%0d", i), rsp_r, fill_a[i] ^ fill_b[i]);
            checkOutput($sformatf("fill_err_%0d", i), rsp_err, 1'b0);
            tick();
        end
        repeat (2) tick();
        checkOutput("fill_drained", busy, 1'b0);
        model_en = 1'b0;

        // Timeout, then next op issues and completes exactly at expiry
        applyStimulus(32'hAAAA0001, 32'h5555_0002, 2'd1, 5'd7);
        tick();
        applyStimulus(32'hBBBB0003, 32'h1234_0004, 2'd2, 5'd8);
        tick();
        req_valid = 1'b0;
        checkOutput("to_start", fpu_start, 1'b1);
        flag = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            flag = flag | rsp_valid;
        end
        checkOutput("to_not_early", flag, 1'b0);
        tick();
        checkOutput("to_rsp_valid", rsp_valid, 1'b1);
        checkOutput("to_rsp_r", rsp_r, 32'h7FC00000);
        checkOutput("to_rsp_err", rsp_err, 1'b1);
        checkOutput("to_rsp_tag", rsp_tag, 5'd7);
        tick();
        tick();
        checkOutput("to_next_start", fpu_start, 1'b1);
        checkOutput("to_next_a", fpu_a, 32'hBBBB0003);
        rsp_ready = 1'b0;
        repeat (TIMEOUT) tick();
        man_done = 1'b1;
        man_r    = 32'h41200000;
        tick();
        man_done = 1'b0;
        checkOutput("exp_rsp_valid", rsp_valid, 1'b1);
        checkOutput("exp_rsp_r", rsp_r, 32'h41200000);
        checkOutput("exp_rsp_err", rsp_err, 1'b0);
        checkOutput("exp_rsp_tag", rsp_tag, 5'd8);

        // Spurious done in RESP and in IDLE
        man_done = 1'b1;
        man_r    = 32'hDEADBEEF;
        tick();
        man_done = 1'b0;
        checkOutput("spur_resp_r", rsp_r, 32'h41200000);
        checkOutput("spur_resp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        man_done = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            tick();
            flag = flag | rsp_valid | fpu_start | busy;
        end
        man_done = 1'b0;
        checkOutput("spur_idle_quiet", flag, 1'b0);

        // Reset mid-WAIT with two entries queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hC000_0000 + 32'(i), 32'h0000_00F0, 2'd3, TAG_W'(20 + i));
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        checkOutput("mrst_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_busy", busy, 1'b0);
        checkOutput("mrst_req_ready", req_ready, 1'b1);
        checkOutput("mrst_fpu_start", fpu_start, 1'b0);
        checkOutput("mrst_fpu_a", fpu_a, 32'h0);
        checkOutput("mrst_fpu_b", fpu_b, 32'h0);
        checkOutput("mrst_fpu_op", fpu_op, 2'd0);
        checkOutput("mrst_rsp_tag", rsp_tag, 5'd0);
        checkOutput("mrst_rsp_err", rsp_err, 1'b0);
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            man_done = (i % 3 == 0);
            tick();
            flag = flag | rsp_valid | fpu_start;
        end
        man_done = 1'b0;
        checkOutput("mrst_no_rsp", flag, 1'b0);
        checkOutput("mrst_idle_busy", busy, 1'b0);

        // Fresh request after reset still works
        model_en = 1'b1;
        applyStimulus(32'h0000_FFFF, 32'h00FF_00FF, 2'd2, 5'd21);
        tick();
        req_valid = 1'b0;
        waitRsp(40);
        checkOutput("post_tag", rsp_tag, 5'd21);
        checkOutput("post_r", rsp_r, 32'h00FF_FF00);
        checkOutput("post_err", rsp_err, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
